// File: rtl/nonce_dispatcher.sv
// Shares one scrypt work unit across NCORES hashing cores: round-robin nonce dispatch,
// round-robin result collection, and a small golden-nonce FIFO for the host readout path.
module nonce_dispatcher #(
  parameter int NCORES     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   run,
  input  logic [31:0]            nonce_start,
  input  logic [NCORES-1:0]      core_idle,
  output logic [NCORES-1:0]      core_start,
  output logic [31:0]            core_nonce,
  input  logic [NCORES-1:0]      core_done,
  input  logic [NCORES-1:0]      core_hit,
  input  logic [32*NCORES-1:0]   core_result,
  output logic [NCORES-1:0]      core_ack,
  input  logic                   fifo_rd,
  output logic                   gn_valid,
  output logic [31:0]            gn_nonce,
  output logic                   gn_overflow,
  output logic [31:0]            nonce_next,
  output logic                   exhausted
);

  localparam int PW = $clog2(NCORES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // First requester at or after start, else the first one below it: {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [NCORES-1:0] req,
                                          input logic [PW-1:0]     start);
    logic          found;
    logic [PW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (!found && req[i] && (i >= int'(start))) begin
        found = 1'b1;
        idx   = PW'(i);
      end
    end
    for (int i = 0; i < NCORES; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        idx   = PW'(i);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] idx);
    return (idx == PW'(NCORES - 1)) ? '0 : idx + PW'(1);
  endfunction

  logic [NCORES-1:0] r_start;
  logic [NCORES-1:0] r_ack;
  logic [NCORES-1:0] r_busy;
  logic [NCORES-1:0] r_stale;
  logic [31:0]       r_cnt;
  logic [31:0]       r_nonce;
  logic              r_exhausted;
  logic [PW-1:0]     r_disp_ptr;
  logic [PW-1:0]     r_coll_ptr;
  logic [PW-1:0]     r_coll_idx_p1;
  logic              r_hit_p1;
  logic [31:0]       r_res_p1;

  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic              r_gn_valid;
  logic [31:0]       r_gn_nonce;
  logic              r_overflow;

  logic [31:0]       w_res [NCORES];
  logic              w_disp_found;
  logic              w_coll_found;
  logic [PW-1:0]     w_disp_idx;
  logic [PW-1:0]     w_coll_idx;
  logic              w_disp_fire;
  logic              w_coll_fire;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_wr;
  logic              w_drop;
  logic [AW-1:0]     w_rd_nxt;

  always_comb begin
    for (int i = 0; i < NCORES; i++) begin
      w_res[i] = core_result[32*i +: 32];
    end
  end

  // Stage p0: selection. A core pulsed last cycle is masked so it cannot be granted twice.
  always_comb begin
    {w_disp_found, w_disp_idx} = rr_pick(core_idle & ~r_start, r_disp_ptr);
    {w_coll_found, w_coll_idx} = rr_pick(core_done & ~r_ack, r_coll_ptr);
    w_disp_fire = w_disp_found & run & ~r_exhausted & ~load;
    w_coll_fire = w_coll_found & ~load;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start     <= '0;
      r_nonce     <= '0;
      r_cnt       <= '0;
      r_exhausted <= 1'b0;
      r_disp_ptr  <= '0;
    end else begin
      r_start <= '0;
      if (load) begin
        r_cnt       <= nonce_start;
        r_exhausted <= 1'b0;
      end else if (w_disp_fire) begin
        r_start    <= {{(NCORES-1){1'b0}}, 1'b1} << w_disp_idx;
        r_nonce    <= r_cnt;
        r_cnt      <= r_cnt + 32'd1;
        r_disp_ptr <= rr_next(w_disp_idx);
        if (r_cnt == 32'hFFFF_FFFF) begin
          r_exhausted <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack      <= '0;
      r_coll_ptr <= '0;
    end else begin
      r_ack <= '0;
      if (w_coll_fire) begin
        r_ack      <= {{(NCORES-1){1'b0}}, 1'b1} << w_coll_idx;
        r_coll_ptr <= rr_next(w_coll_idx);
      end
    end
  end

  // Stage p1: the granted core's result, consumed while its ack pulse is high.
  always_ff @(posedge clk) begin
    if (w_coll_fire) begin
      r_coll_idx_p1 <= w_coll_idx;
      r_hit_p1      <= core_hit[w_coll_idx];
      r_res_p1      <= w_res[w_coll_idx];
    end
  end

  // Work is outstanding from its start pulse until its ack; a load turns it stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy  <= '0;
      r_stale <= '0;
    end else begin
      r_busy <= (r_busy & ~r_ack) | r_start;
      if (load) begin
        r_stale <= (r_busy & ~r_ack) | r_start;
      end else begin
        r_stale <= r_stale & ~r_ack;
      end
    end
  end

  always_comb begin
    w_full   = (r_count == CW'(FIFO_DEPTH));
    w_empty  = (r_count == '0);
    w_push   = (|r_ack) & r_hit_p1 & ~r_stale[r_coll_idx_p1] & ~load;
    w_pop    = fifo_rd & ~w_empty & ~load;
    w_wr     = w_push & (~w_full | w_pop);
    w_drop   = w_push & w_full & ~w_pop;
    w_rd_nxt = r_rd_ptr + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= r_res_p1;
    end
  end

  // Stage p2: FIFO state; the head is kept in its own register so outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_gn_valid <= 1'b0;
      r_gn_nonce <= '0;
      r_overflow <= 1'b0;
    end else if (load) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_gn_valid <= 1'b0;
      r_gn_nonce <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_nxt;
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_wr) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_empty) begin
        if (w_wr) begin
          r_gn_valid <= 1'b1;
          r_gn_nonce <= r_res_p1;
        end
      end else if (w_pop) begin
        if (r_count != CW'(1)) begin
          r_gn_nonce <= r_mem[w_rd_nxt];
        end else if (w_wr) begin
          r_gn_nonce <= r_res_p1;
        end else begin
          r_gn_valid <= 1'b0;
        end
      end
    end
  end

  assign core_start  = r_start;
  assign core_nonce  = r_nonce;
  assign core_ack    = r_ack;
  assign gn_valid    = r_gn_valid;
  assign gn_nonce    = r_gn_nonce;
  assign gn_overflow = r_overflow;
  assign nonce_next  = r_cnt;
  assign exhausted   = r_exhausted;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Scoreboard bench for nonce_dispatcher: directed stimulus queues expected starts, acks
// and golden nonces; a monitor compares them as the DUT presents them.
module tb_nonce_dispatcher;
  localparam int NC = 4;
  localparam int FD = 8;

  typedef struct {
    logic [NC-1:0] vec;
    logic [31:0]   nonce;
  } start_t;

  logic              clk;
  logic              reset;
  logic              load;
  logic              run;
  logic [31:0]       nonce_start;
  logic [NC-1:0]     core_idle;
  logic [NC-1:0]     core_start;
  logic [31:0]       core_nonce;
  logic [NC-1:0]     core_done;
  logic [NC-1:0]     core_hit;
  logic [32*NC-1:0]  core_result;
  logic [NC-1:0]     core_ack;
  logic              fifo_rd;
  logic              gn_valid;
  logic [31:0]       gn_nonce;
  logic              gn_overflow;
  logic [31:0]       nonce_next;
  logic              exhausted;

  start_t        exp_start[$];
  logic [NC-1:0] exp_ack[$];
  logic [31:0]   exp_gn[$];
  int            checks;
  int            failures;
  int            n_start;
  int            n_ack;
  int            n_gn;
  logic          rd_enable;
  logic [NC-1:0] prev_start;
  logic [NC-1:0] prev_ack;

  nonce_dispatcher #(.NCORES(NC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .load(load), .run(run), .nonce_start(nonce_start),
    .core_idle(core_idle), .core_start(core_start), .core_nonce(core_nonce),
    .core_done(core_done), .core_hit(core_hit), .core_result(core_result),
    .core_ack(core_ack), .fifo_rd(fifo_rd), .gn_valid(gn_valid), .gn_nonce(gn_nonce),
    .gn_overflow(gn_overflow), .nonce_next(nonce_next), .exhausted(exhausted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_start(input logic [NC-1:0] vec, input logic [31:0] nonce);
    start_t s;
    s.vec   = vec;
    s.nonce = nonce;
    exp_start.push_back(s);
  endtask

  // Core model: a core drops idle/done in the cycle after it saw start/ack.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      core_idle  = core_idle & ~prev_start;
      core_done  = core_done & ~prev_ack;
      prev_start = core_start;
      prev_ack   = core_ack;
    end
  endtask

  initial begin
    start_t e;
    fifo_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (core_start != '0) begin
        n_start++;
        if (exp_start.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL start_unexpected actual=%h required=none", core_start);
        end else begin
          e = exp_start.pop_front();
          chk("start_vec", 32'(core_start), 32'(e.vec));
          chk("start_nonce", core_nonce, e.nonce);
        end
      end
      if (core_ack != '0) begin
        n_ack++;
        if (exp_ack.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ack_unexpected actual=%h required=none", core_ack);
        end else begin
          chk("ack_vec", 32'(core_ack), 32'(exp_ack.pop_front()));
        end
      end
      if (rd_enable && gn_valid) begin
        n_gn++;
        if (exp_gn.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL gn_unexpected actual=%h required=none", gn_nonce);
        end else begin
          chk("gn_nonce", gn_nonce, exp_gn.pop_front());
        end
        fifo_rd = 1'b1;
      end else begin
        fifo_rd = 1'b0;
      end
    end
  end

  initial begin
    checks = 0; failures = 0; n_start = 0; n_ack = 0; n_gn = 0;
    reset = 1'b1; load = 1'b0; run = 1'b0; nonce_start = '0;
    core_idle = '0; core_done = '0; core_hit = '0; core_result = '0;
    rd_enable = 1'b0; prev_start = '0; prev_ack = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_core_ack", 32'(core_ack), 32'd0);
    chk("rst_core_nonce", core_nonce, 32'd0);
    chk("rst_gn_valid", 32'(gn_valid), 32'd0);
    chk("rst_gn_nonce", gn_nonce, 32'd0);
    chk("rst_gn_overflow", 32'(gn_overflow), 32'd0);
    chk("rst_nonce_next", nonce_next, 32'd0);
    chk("rst_exhausted", 32'(exhausted), 32'd0);
    reset = 1'b0;
    step(2);

    // Four idle cores receive consecutive nonces in round-robin order.
    nonce_start = 32'h100; load = 1'b1;
    step(1);
    load = 1'b0; run = 1'b1; core_idle = 4'b1111;
    expect_start(4'b0001, 32'h100);
    expect_start(4'b0010, 32'h101);
    expect_start(4'b0100, 32'h102);
    expect_start(4'b1000, 32'h103);
    step(8);
    chk("nonce_next_after4", nonce_next, 32'h104);
    chk("starts_after4", 32'(n_start), 32'd4);

    // Simultaneous hits from cores 1 and 3.
    core_result[32*1 +: 32] = 32'h101;
    core_result[32*3 +: 32] = 32'h103;
    core_hit = 4'b1010; core_done = 4'b1010;
    exp_ack.push_back(4'b0010);
    exp_ack.push_back(4'b1000);
    exp_gn.push_back(32'h101);
    exp_gn.push_back(32'h103);
    step(3);
    chk("gn_valid_two", 32'(gn_valid), 32'd1);
    chk("gn_head_two", gn_nonce, 32'h101);
    rd_enable = 1'b1;
    step(6);
    chk("gn_valid_drained", 32'(gn_valid), 32'd0);
    chk("gn_reads_two", 32'(n_gn), 32'd2);
    core_hit = '0;

    // Load while cores 0 and 2 are busy: core 2's old result is acked but not pushed.
    run = 1'b0; nonce_start = 32'h200; load = 1'b1;
    step(1);
    load = 1'b0;
    core_result[32*2 +: 32] = 32'h102;
    core_hit = 4'b0100; core_done = 4'b0100;
    exp_ack.push_back(4'b0100);
    step(6);
    chk("stale_no_push_valid", 32'(gn_valid), 32'd0);
    chk("stale_no_push_reads", 32'(n_gn), 32'd2);
    run = 1'b1; core_idle = 4'b0100;
    expect_start(4'b0100, 32'h200);
    step(4);
    run = 1'b0;
    core_result[32*2 +: 32] = 32'h200;
    core_hit = 4'b0100; core_done = 4'b0100;
    exp_ack.push_back(4'b0100);
    exp_gn.push_back(32'h200);
    step(6);
    chk("fresh_hit_reads", 32'(n_gn), 32'd3);
    chk("fresh_hit_drained", 32'(gn_valid), 32'd0);
    core_hit = '0;

    // run low: idle cores are not started, a pending result is still acked.
    core_idle = 4'b1111;
    core_result[32*1 +: 32] = 32'h55;
    core_done = 4'b0010;
    exp_ack.push_back(4'b0010);
    step(5);
    chk("run_low_no_start", 32'(n_start), 32'd5);
    chk("run_low_acks", 32'(n_ack), 32'd5);
    core_idle = '0;

    // Nine hits with no reads: eight kept, ninth dropped with overflow.
    rd_enable = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k == 8) chk("ovf_before_ninth", 32'(gn_overflow), 32'd0);
      core_result[32*1 +: 32] = 32'h1000 + 32'(k);
      core_hit = 4'b0010; core_done = 4'b0010;
      exp_ack.push_back(4'b0010);
      if (k < 8) exp_gn.push_back(32'h1000 + 32'(k));
      step(3);
    end
    chk("ovf_after_ninth", 32'(gn_overflow), 32'd1);
    chk("full_head", gn_nonce, 32'h1000);
    // Push and read together on a full FIFO.
    core_result[32*1 +: 32] = 32'h2000;
    core_hit = 4'b0010; core_done = 4'b0010;
    exp_ack.push_back(4'b0010);
    exp_gn.push_back(32'h2000);
    rd_enable = 1'b1;
    step(1);
    rd_enable = 1'b0;
    step(3);
    chk("full_pushpop_reads", 32'(n_gn), 32'd4);
    chk("full_pushpop_ovf", 32'(gn_overflow), 32'd1);
    rd_enable = 1'b1;
    step(12);
    rd_enable = 1'b0;
    chk("full_drain_reads", 32'(n_gn), 32'd12);
    chk("full_drain_valid", 32'(gn_valid), 32'd0);
    core_hit = '0;

    // Range wrap: 0xFFFFFFFE, 0xFFFFFFFF, then exhausted.
    nonce_start = 32'hFFFF_FFFE; load = 1'b1;
    step(1);
    load = 1'b0; run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      core_idle = 4'b0010;
      if (k < 2) expect_start(4'b0010, 32'hFFFF_FFFE + 32'(k));
      step(4);
    end
    chk("wrap_exhausted", 32'(exhausted), 32'd1);
    chk("wrap_nonce_next", nonce_next, 32'd0);
    chk("wrap_starts", 32'(n_start), 32'd7);
    run = 1'b0; core_idle = '0;
    nonce_start = 32'h300; load = 1'b1;
    step(1);
    load = 1'b0;
    chk("load_clears_exhausted", 32'(exhausted), 32'd0);
    chk("load_nonce_next", nonce_next, 32'h300);

    // Reset in the middle of a start pulse.
    run = 1'b1; core_idle = 4'b0001;
    expect_start(4'b0001, 32'h300);
    step(1);
    run = 1'b0; core_idle = '0;
    reset = 1'b1;
    #1;
    chk("midrst_core_start", 32'(core_start), 32'd0);
    chk("midrst_core_nonce", core_nonce, 32'd0);
    chk("midrst_nonce_next", nonce_next, 32'd0);
    step(2);
    reset = 1'b0;
    step(3);
    chk("left_starts", 32'(exp_start.size()), 32'd0);
    chk("left_acks", 32'(exp_ack.size()), 32'd0);
    chk("left_gn", 32'(exp_gn.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nonce_dispatcher.md
# nonce_dispatcher

Work scheduler that shares one scrypt work unit across `NCORES` hashing cores on a single FPGA of the Ztex 1.15y miner. It hands out consecutive nonces to idle cores round-robin, collects core results round-robin, and buffers golden nonces in a small FIFO read by the host-interface logic. It sits between the host command/readout path and the core array.

## Interface
- `NCORES`, 4, number of hashing cores (2..8)
- `FIFO_DEPTH`, 8, golden-nonce FIFO entries (power of two)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `load`  in  1  one-cycle pulse: new work loaded; restart nonce range
- `run`  in  1  level; dispatch allowed when high
- `nonce_start`  in  32  first nonce of the range, sampled on `load`
- `core_idle`  in  NCORES  core i ready for a nonce (level)
- `core_start`  out  NCORES  one-hot start pulse
- `core_nonce`  out  32  nonce for the core pulsed on `core_start`
- `core_done`  in  NCORES  core i holds a result (level until acked)
- `core_hit`  in  NCORES  result of core i meets target; valid with `core_done[i]`
- `core_result`  in  32*NCORES  nonce echoed by core i, bits [32i+31:32i]
- `core_ack`  out  NCORES  one-hot result-accept pulse
- `fifo_rd`  in  1  pop FIFO head
- `gn_valid`  out  1  FIFO non-empty
- `gn_nonce`  out  32  FIFO head; valid while `gn_valid`
- `gn_overflow`  out  1  sticky; golden nonce dropped due to full FIFO
- `nonce_next`  out  32  next nonce to be dispatched
- `exhausted`  out  1  sticky; range wrapped past 0xFFFFFFFF

## Operation
- Reset: all outputs 0, nonce counter 0, both round-robin pointers 0, FIFO empty, all stale bits 0, masks 0.
- Dispatch: in cycle t, if `run`=1, `exhausted`=0, `load`=0, pick the first core i with `core_idle[i]`=1 and not masked, searching from (last dispatch grant + 1) mod NCORES. At t+1: `core_start`=one-hot(i), `core_nonce`=counter value at t; counter increments. Core i is masked from dispatch selection during t+1. At most one dispatch per cycle.
- Counter wrap: dispatching 0xFFFFFFFF sets the counter to 0 and `exhausted`=1; no further dispatch until `load`.
- Collection: in cycle t, if `load`=0, pick the first unmasked core with `core_done`=1, searching from (last collect grant + 1) mod NCORES. The selected core's `core_hit` and `core_result` are registered. At t+1: `core_ack`=one-hot(i); if hit and `stale[i]`=0, push result into FIFO. `stale[i]` clears at t+1. Core i is masked from collection during t+1. At most one collection per cycle. Dispatch and collection are independent and may target the same core in the same cycle.
- FIFO: push when full drops the value and sets `gn_overflow`. Simultaneous push and `fifo_rd` when full: both take effect, count unchanged. `fifo_rd` when empty is ignored. Simultaneous push and pop when empty: the pushed entry remains.
- Load: counter := `nonce_start`; `exhausted`, `gn_overflow`, FIFO flushed; pointers unchanged. Every core with outstanding work (started, not yet acked), including a core whose `core_start` is high in the load cycle, gets `stale` set. A push registered in the load cycle is discarded. No selections are made in the load cycle.
- `run` low: no new dispatch. Collection continues.

## Timing
- Dispatch and collect latency: 1 cycle from selection to pulse. Pulses last exactly 1 cycle.
- Cores drop `core_idle`/`core_done` in the cycle after seeing `core_start`/`core_ack`. The one-cycle masks guarantee no double grant.
- `gn_valid` and `gn_nonce` are registered. A push at t+1 is visible at t+2.
- Reset asserted mid-operation immediately forces all outputs to 0. In-flight work is forgotten and not marked stale.

## Test plan
- Four idle cores, `nonce_start`=0x100, `load` then `run`=1 → starts to cores 0,1,2,3 on consecutive cycles with nonces 0x100..0x103. `nonce_next`=0x104.
- Cores 1 and 3 raise `done` with hit in the same cycle → acks to 1 then 3 on consecutive cycles. FIFO yields both results in that order. `gn_valid` drops after two `fifo_rd`s.
- `nonce_start`=0xFFFFFFFE, one idle core repeatedly → nonces 0xFFFFFFFE, 0xFFFFFFFF. Then `exhausted`=1, no further start, `nonce_next`=0.
- Nine hits with no reads, FIFO_DEPTH=8 → 8 entries retained. `gn_overflow`=1 after the ninth ack. Push plus read on a full FIFO keeps count at 8.
- Core 2 busy, `load` pulsed, then core 2 reports hit → ack issued, no FIFO push. A later hit from core 2 (new nonce) is pushed.
- `run`=0 with idle cores → no `core_start`. Pending `core_done` still acked.
